// File: rtl/multi_func_barrel_shifter_pipe.sv
// Purpose : pipelined rotate / logical / arithmetic barrel shifter, one register stage per amount bit.
// Latency : SW edges from acceptance to y; full throughput of one word per clock.
// Backpr. : out_ready low stalls the last stage; bubbles ahead of it are filled; capacity SW words.
// Ports   : clk, reset (async, active-high); in_valid/in_ready + a/amt/lr/op in;
//           out_valid/out_ready + y out; busy = any stage holding a word.
module multi_func_barrel_shifter_pipe #(
  parameter int DW = 8,
  parameter int SW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [SW-1:0] amt,
  input  logic          lr,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y,
  output logic          busy
);

  // Per-stage registers
  logic [SW-1:0] v_q;
  logic [DW-1:0] d_q   [SW];
  logic [SW-1:0] amt_q [SW];
  logic          lr_q  [SW];
  logic [1:0]    op_q  [SW];
  logic          s_q   [SW];

  // Upstream view of each stage (stage 0 sees the input port)
  logic [SW-1:0] up_v;
  logic [DW-1:0] up_d   [SW];
  logic [SW-1:0] up_amt [SW];
  logic          up_lr  [SW];
  logic [1:0]    up_op  [SW];
  logic          up_s   [SW];
  logic [DW-1:0] nxt_d  [SW];

  logic [SW-1:0] rdy;

  // One fixed-size step of the shifter. m is a constant power of two per stage.
  function automatic logic [DW-1:0] stage_fn(input logic [DW-1:0] d, input int unsigned m,
                                             input logic l, input logic [1:0] o, input logic s);
    logic [DW-1:0] ones;
    logic [DW-1:0] r;
    ones = '1;
    r    = l ? (d << m) : (d >> m);
    if (o == 2'b00 || o == 2'b11) begin
      r = l ? ((d << m) | (d >> (DW - m))) : ((d >> m) | (d << (DW - m)));
    end else if (o == 2'b10 && !l && s) begin
      // arithmetic right: vacated MSBs take the sign captured at acceptance
      r = r | ~(ones >> m);
    end
    return r;
  endfunction

  // rdy_k = !v_k | rdy_{k+1}, unrolled: a stage may load if the output drains
  // or any stage at or after it is empty.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < SW; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < SW; j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    up_v      = '0;
    up_v[0]   = in_valid;
    up_d[0]   = a;
    up_amt[0] = amt;
    up_lr[0]  = lr;
    up_op[0]  = op;
    up_s[0]   = a[DW-1];
    for (int k = 1; k < SW; k++) begin
      up_v[k]   = v_q[k-1];
      up_d[k]   = d_q[k-1];
      up_amt[k] = amt_q[k-1];
      up_lr[k]  = lr_q[k-1];
      up_op[k]  = op_q[k-1];
      up_s[k]   = s_q[k-1];
    end
    for (int k = 0; k < SW; k++) begin
      nxt_d[k] = up_amt[k][k] ? stage_fn(up_d[k], 32'(1) << k, up_lr[k], up_op[k], up_s[k])
                              : up_d[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < SW; k++) begin
        d_q[k]   <= '0;
        amt_q[k] <= '0;
        lr_q[k]  <= 1'b0;
        op_q[k]  <= 2'b00;
        s_q[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (rdy[k]) begin
          v_q[k]   <= up_v[k];
          d_q[k]   <= nxt_d[k];
          amt_q[k] <= up_amt[k];
          lr_q[k]  <= up_lr[k];
          op_q[k]  <= up_op[k];
          s_q[k]   <= up_s[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[SW-1];
  assign y         = d_q[SW-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_multi_func_barrel_shifter_pipe.sv
// Purpose : scoreboard bench for multi_func_barrel_shifter_pipe (DW=8), directed and random words.
// Latency : expects each result SW-1 edges after its acceptance edge when the output never stalls.
// Backpr. : exercises output stalls, full-pipe input blocking and reset with words in flight.
module tb_multi_func_barrel_shifter_pipe;
  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [SW-1:0] amt;
  logic          lr;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] y;
  logic          busy;

  multi_func_barrel_shifter_pipe #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .amt(amt),
    .lr(lr), .op(op), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] y;
    int            acc;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  bit strict = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each result bit picks its source bit by index arithmetic on the full amount.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] ia, input int iamt,
                                          input logic ilr, input logic [1:0] iop);
    logic [DW-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      src = ilr ? i - iamt : i + iamt;
      if (iop == 2'b00 || iop == 2'b11) r[i] = ia[(src + DW) % DW];
      else if (src >= 0 && src < DW)     r[i] = ia[src];
      else                               r[i] = (iop == 2'b10 && !ilr) ? ia[DW-1] : 1'b0;
    end
    return r;
  endfunction

  // Monitor: pops an expectation for every output transfer.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got y=0x%0h with no word outstanding (cycle %0d)", y, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("y", y, e.y);
          if (strict) check("latency", cyc - e.acc, SW - 1);
          n_pop++;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] ia, input logic [SW-1:0] iamt, input logic ilr,
                      input logic [1:0] iop, input logic [DW-1:0] iexp);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ia; amt = iamt; lr = ilr; op = iop;
      #1;
      if (in_ready) begin
        q.push_back('{iexp, cyc + 1});
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
  endtask

  task automatic send_rand();
    logic [DW-1:0] ra;
    logic [SW-1:0] ramt;
    logic          rlr;
    logic [1:0]    rop;
    ra = DW'($urandom); ramt = SW'($urandom); rlr = 1'($urandom); rop = 2'($urandom);
    send(ra, ramt, rlr, rop, model(ra, int'(ramt), rlr, rop));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
    #3;
    check(name, q.size(), 0);
  endtask

  initial begin
    int p0;
    int nacc;
    logic [DW-1:0] y0;
    logic [DW-1:0] ra;
    logic [SW-1:0] ramt;
    logic          rlr;
    logic [1:0]    rop;
    bit            pending;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; amt = '0; lr = 1'b0; op = 2'b00;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // rotate
    send(8'h96, 3'd1, 1'b0, 2'b00, 8'h4B);
    send(8'h96, 3'd3, 1'b1, 2'b00, 8'hB4);
    send(8'h96, 3'd1, 1'b0, 2'b11, 8'h4B);
    send(8'h96, 3'd3, 1'b1, 2'b11, 8'hB4);
    // logical / arithmetic right
    send(8'h96, 3'd3, 1'b0, 2'b01, 8'h12);
    send(8'h96, 3'd3, 1'b0, 2'b10, 8'hF2);
    send(8'h76, 3'd3, 1'b0, 2'b10, 8'h0E);
    // left shifts and zero amount
    send(8'h96, 3'd4, 1'b1, 2'b01, 8'h60);
    send(8'h96, 3'd4, 1'b1, 2'b10, 8'h60);
    for (int o = 0; o < 4; o++) begin
      send(8'h96, 3'd0, 1'b0, 2'(o), 8'h96);
      send(8'h96, 3'd0, 1'b1, 2'(o), 8'h96);
    end
    drain("directed_drain");

    // back-to-back burst of 8
    p0 = n_pop;
    for (int i = 0; i < 8; i++) send_rand();
    idle(6);
    check("burst_count", n_pop - p0, 8);
    check("burst_idle_busy", busy, 0);

    // output stall: exactly SW words fit, inputs keep changing while blocked
    strict = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ra = DW'($urandom); ramt = SW'($urandom); rlr = 1'($urandom); rop = 2'($urandom);
      in_valid = 1'b1; a = ra; amt = ramt; lr = rlr; op = rop;
      #1;
      if (in_ready) begin
        q.push_back('{model(ra, int'(ramt), rlr, rop), cyc + 1});
        nacc++;
      end
    end
    check("stall_accepted", nacc, SW);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_busy", busy, 1);
    y0 = y;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a = DW'($urandom); amt = SW'($urandom); lr = 1'($urandom); op = 2'($urandom);
      #1;
      check("stall_y_stable", y, y0);
      check("stall_in_ready_hold", in_ready, 0);
    end
    p0 = n_pop;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    idle(5);
    check("release_count", n_pop - p0, SW);
    check("release_empty", out_valid, 0);
    strict = 1'b1;

    // reset with two words in flight
    send_rand();
    send_rand();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    check("post_rst_busy", busy, 0);
    send(8'h01, 3'd7, 1'b1, 2'b01, 8'h80);
    drain("post_rst_drain");

    // random traffic with random backpressure and input gaps
    strict  = 1'b0;
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        ra = DW'($urandom); ramt = SW'($urandom); rlr = 1'($urandom); rop = 2'($urandom);
        a = ra; amt = ramt; lr = rlr; op = rop;
        pending = 1'b1;
      end
      in_valid = pending;
      #1;
      if (pending && in_ready) begin
        q.push_back('{model(ra, int'(ramt), rlr, rop), cyc + 1});
        pending = 1'b0;
      end
    end
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
